s_type_store_unit: RTL and testbench
====================================

Name: s_type_store_unit

Overview:
- Store-path decoder for the single-cycle RV32I core.
- Decodes S-type instructions (SB/SH/SW) from the instruction word and produces the data-memory byte write enables and the lane-aligned store data.
- Also produces the sign-extended S-immediate and raises a misalignment fault.
- Combinational datapath; fault status is registered.

Parameters:
- XLEN, 32, data/address width; only 32 is supported.
- STORE_OPCODE, 7'b0100011, opcode value that identifies S-type instructions.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-low reset
- idata  input  32  current instruction word
- iaddr  input  32  PC of the current instruction
- daddr  input  32  effective data address (rs1 + imm), computed externally
- rs2_data  input  32  store source register value
- we_S  output  4  byte write enables; bit i enables byte lane i (daddr[1:0]==i)
- wdata_S  output  32  store data replicated/shifted into the addressed lanes
- imm_S  output  32  sign-extended {idata[31:25], idata[11:7]}
- is_store  output  1  idata[6:0] == STORE_OPCODE and funct3 is legal
- misaligned  output  1  combinational misalignment flag for the current store
- fault_valid  output  1  sticky registered fault flag
- fault_pc  output  32  iaddr of the first faulting store
- fault_addr  output  32  daddr of the first faulting store

Behaviour:
Decode:
- func = {idata[30], idata[25], idata[14:12]}.
- Legal store funct3 values: SB = 000, SH = 001, SW = 010. idata[30] and idata[25] are ignored for stores.
- is_store = opcode match AND funct3 is one of the legal values.
- Opcode mismatch or any other funct3: is_store=0, we_S=0000, misaligned=0.

Byte enables (only when is_store=1):
- SB: we_S = 4'b0001 << daddr[1:0]. Never misaligned.
- SH: when daddr[0]==0, we_S = 4'b0011 << daddr[1:0]. When daddr[0]==1, misaligned=1 and we_S=0000.
- SW: when daddr[1:0]==00, we_S=1111. Otherwise misaligned=1 and we_S=0000.
- A misaligned store never writes memory.

Write data:
- SB: wdata_S = {4{rs2_data[7:0]}}.
- SH: wdata_S = {2{rs2_data[15:0]}}.
- SW: wdata_S = rs2_data.
- Non-store: wdata_S = 0.

Immediate:
- imm_S is always driven from idata, independent of is_store.

Timing:
- we_S, wdata_S, imm_S, is_store and misaligned are purely combinational, with zero-cycle latency from the inputs.

Fault register (updates on rising edge of clk):
- reset==0: fault_valid=0, fault_pc=0, fault_addr=0. Reset has priority over capture.
- Otherwise, if misaligned && !fault_valid: fault_valid<=1, fault_pc<=iaddr, fault_addr<=daddr.
- Once set, the fault registers hold until reset. Later faults do not overwrite them.
- Reset asserted in the same cycle as a fault: the fault is not captured.

Output values during reset:
- Combinational outputs still follow their inputs.
- Registered outputs read 0 after the reset edge.

Test Plan:
1. SB idata=32'h00208023 (funct3 000, opcode 0100011), daddr=1, rs2_data=32'h000000AB -> we_S=0010, wdata_S=ABABABAB, misaligned=0.
2. SH funct3=001, daddr=1 -> we_S=0000, misaligned=1. On the next clk, fault_valid=1, fault_addr=1, fault_pc=iaddr. Repeat with daddr=2, rs2_data=32'h1234 -> we_S=1100, wdata_S=12341234.
3. SW funct3=010: daddr=1 -> we_S=0000, misaligned=1. daddr=0, rs2_data=32'hDEADBEEF -> we_S=1111, wdata_S=DEADBEEF.
4. Immediate check: idata=32'hFE000FA3 -> imm_S=32'hFFFFFFFF. idata bits[31:25]=0000001, [11:7]=00010 -> imm_S=32'h00000022.
5. Non-store / illegal encodings: opcode 0110011 or store funct3=011 -> is_store=0, we_S=0000, misaligned=0, and no fault is captured.
6. Reset and sticky fault:
   - Two consecutive misaligned stores at daddr=1 then 3 -> fault_addr stays 1.
   - Drive reset=0 for one edge -> all fault registers read 0.
   - A fault coincident with reset=0 is not captured.

Source files
------------

// File: rtl/s_type_store_unit_if.sv
// Store-path bundle between the core and the S-type store unit.
// The master side supplies the instruction/address/data inputs; the slave
// side (the store unit) returns byte enables, lane data, immediate and fault
// status.
interface s_type_store_unit_if #(
  parameter int XLEN = 32
);
  logic [31:0]     idata;
  logic [XLEN-1:0] iaddr;
  logic [XLEN-1:0] daddr;
  logic [XLEN-1:0] rs2_data;
  logic [3:0]      we_S;
  logic [XLEN-1:0] wdata_S;
  logic [XLEN-1:0] imm_S;
  logic            is_store;
  logic            misaligned;
  logic            fault_valid;
  logic [XLEN-1:0] fault_pc;
  logic [XLEN-1:0] fault_addr;

  modport master (
    output idata, iaddr, daddr, rs2_data,
    input  we_S, wdata_S, imm_S, is_store, misaligned,
    input  fault_valid, fault_pc, fault_addr
  );

  modport slave (
    input  idata, iaddr, daddr, rs2_data,
    output we_S, wdata_S, imm_S, is_store, misaligned,
    output fault_valid, fault_pc, fault_addr
  );
endinterface

// File: rtl/s_type_store_unit.sv
// S-type store decoder for the single-cycle RV32I core.
// Decodes SB/SH/SW, produces byte-lane write enables and lane-replicated
// store data, the sign-extended S-immediate, and a sticky record of the
// first misaligned store (its PC and effective address).
module s_type_store_unit #(
  parameter int          XLEN         = 32,
  parameter logic [6:0]  STORE_OPCODE = 7'b0100011
) (
  input  logic                  clk,
  input  logic                  reset,
  s_type_store_unit_if.slave    sif
);

  localparam logic [2:0] F3_SB = 3'b000;
  localparam logic [2:0] F3_SH = 3'b001;
  localparam logic [2:0] F3_SW = 3'b010;

  // Sign-extend the split S-immediate {idata[31:25], idata[11:7]}.
  function automatic logic signed [XLEN-1:0] sext_imm_s(input logic [31:0] insn);
    logic signed [11:0] imm12;
    imm12 = $signed({insn[31:25], insn[11:7]});
    return XLEN'(imm12);
  endfunction

  // Byte-lane enables for an aligned access; misaligned accesses write nothing.
  function automatic logic [3:0] lane_enables(input logic [2:0] f3,
                                              input logic [1:0] off);
    logic [3:0] we;
    we = 4'b0000;
    case (f3)
      F3_SB:   we = 4'b0001 << off;
      F3_SH:   we = off[0] ? 4'b0000 : (4'b0011 << off);
      F3_SW:   we = (off == 2'b00) ? 4'b1111 : 4'b0000;
      default: we = 4'b0000;
    endcase
    return we;
  endfunction

  // Alignment violation for a legal store width at the given byte offset.
  function automatic logic is_misaligned(input logic [2:0] f3,
                                         input logic [1:0] off);
    logic bad;
    bad = 1'b0;
    case (f3)
      F3_SH:   bad = off[0];
      F3_SW:   bad = (off != 2'b00);
      default: bad = 1'b0;
    endcase
    return bad;
  endfunction

  // Replicate the source value so every candidate lane carries the datum.
  function automatic logic [XLEN-1:0] lane_data(input logic [2:0]      f3,
                                                input logic [XLEN-1:0] src);
    logic [XLEN-1:0] d;
    d = '0;
    case (f3)
      F3_SB:   d = {4{src[7:0]}};
      F3_SH:   d = {2{src[15:0]}};
      F3_SW:   d = src;
      default: d = '0;
    endcase
    return d;
  endfunction

  logic [6:0]             opcode;
  logic [2:0]             funct3;
  logic [1:0]             byte_off;
  logic                   opcode_hit;
  logic                   funct3_legal;
  logic                   store_hit;
  logic                   store_misaligned;
  logic [3:0]             store_we;
  logic [XLEN-1:0]        store_wdata;
  logic signed [XLEN-1:0] store_imm;

  logic                   fault_valid_q, fault_valid_d;
  logic [XLEN-1:0]        fault_pc_q,    fault_pc_d;
  logic [XLEN-1:0]        fault_addr_q,  fault_addr_d;

  assign opcode   = sif.idata[6:0];
  assign funct3   = sif.idata[14:12];
  assign byte_off = sif.daddr[1:0];

  // Decode the store, then derive enables, lane data and alignment status.
  always_comb begin
    opcode_hit       = (opcode == STORE_OPCODE);
    funct3_legal     = (funct3 == F3_SB) || (funct3 == F3_SH) || (funct3 == F3_SW);
    store_hit        = opcode_hit && funct3_legal;
    store_we         = 4'b0000;
    store_wdata      = '0;
    store_misaligned = 1'b0;
    if (store_hit) begin
      store_we         = lane_enables(funct3, byte_off);
      store_wdata      = lane_data(funct3, sif.rs2_data);
      store_misaligned = is_misaligned(funct3, byte_off);
    end
    store_imm = sext_imm_s(sif.idata);
  end

  // Capture only the first misaligned store; later ones leave the record intact.
  always_comb begin
    fault_valid_d = fault_valid_q;
    fault_pc_d    = fault_pc_q;
    fault_addr_d  = fault_addr_q;
    if (store_misaligned && !fault_valid_q) begin
      fault_valid_d = 1'b1;
      fault_pc_d    = sif.iaddr;
      fault_addr_d  = sif.daddr;
    end
  end

  // Fault record; reset wins over a coincident capture.
  always_ff @(posedge clk) begin
    if (!reset) begin
      fault_valid_q <= 1'b0;
      fault_pc_q    <= '0;
      fault_addr_q  <= '0;
    end else begin
      fault_valid_q <= fault_valid_d;
      fault_pc_q    <= fault_pc_d;
      fault_addr_q  <= fault_addr_d;
    end
  end

  assign sif.is_store    = store_hit;
  assign sif.we_S        = store_we;
  assign sif.wdata_S     = store_wdata;
  assign sif.imm_S       = store_imm;
  assign sif.misaligned  = store_misaligned;
  assign sif.fault_valid = fault_valid_q;
  assign sif.fault_pc    = fault_pc_q;
  assign sif.fault_addr  = fault_addr_q;

endmodule

// File: tb/tb_s_type_store_unit.sv
// Directed bench for s_type_store_unit: decode, lane enables/data, immediate,
// and the sticky fault record across reset.
module tb_s_type_store_unit;

  logic clk;
  logic reset;
  int   tests;
  int   failed;

  s_type_store_unit_if #(.XLEN(32)) sif ();

  s_type_store_unit #(.XLEN(32), .STORE_OPCODE(7'b0100011)) dut (
    .clk   (clk),
    .reset (reset),
    .sif   (sif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Build an S-type word: imm=0 except where given, rs2=x2, rs1=x1.
  function automatic logic [31:0] mk(input logic [6:0] op, input logic [2:0] f3);
    return {7'b0000000, 5'd2, 5'd1, f3, 5'b00000, op};
  endfunction

  task automatic drive(input logic [31:0] insn, input logic [31:0] pc,
                       input logic [31:0] addr, input logic [31:0] src);
    sif.idata    = insn;
    sif.iaddr    = pc;
    sif.daddr    = addr;
    sif.rs2_data = src;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  localparam logic [6:0] OP_S = 7'b0100011;
  localparam logic [6:0] OP_R = 7'b0110011;

  initial begin
    tests  = 0;
    failed = 0;
    reset  = 1'b0;
    drive(32'h0, 32'h0, 32'h0, 32'h0);

    // Reset state, with a misaligned store present during the reset edge.
    drive(mk(OP_S, 3'b001), 32'h0000_0040, 32'h1, 32'h0);
    chk("mis_during_reset", {31'b0, sif.misaligned}, 32'h1);
    tick();
    chk("rst_fault_valid", {31'b0, sif.fault_valid}, 32'h0);
    chk("rst_fault_pc", sif.fault_pc, 32'h0);
    chk("rst_fault_addr", sif.fault_addr, 32'h0);
    reset = 1'b1;

    // SB at daddr=1.
    drive(32'h0020_8023, 32'h0000_0010, 32'h1, 32'h0000_00AB);
    chk("sb_is_store", {31'b0, sif.is_store}, 32'h1);
    chk("sb_we", {28'b0, sif.we_S}, 32'h2);
    chk("sb_wdata", sif.wdata_S, 32'hABAB_ABAB);
    chk("sb_mis", {31'b0, sif.misaligned}, 32'h0);
    drive(32'h0020_8023, 32'h0000_0014, 32'h3, 32'h1234_5678);
    chk("sb3_we", {28'b0, sif.we_S}, 32'h8);
    chk("sb3_wdata", sif.wdata_S, 32'h7878_7878);
    tick();
    chk("sb_no_fault", {31'b0, sif.fault_valid}, 32'h0);

    // SH misaligned at daddr=1 -> first fault captured.
    drive(mk(OP_S, 3'b001), 32'h0000_0100, 32'h1, 32'h0000_1234);
    chk("sh1_we", {28'b0, sif.we_S}, 32'h0);
    chk("sh1_mis", {31'b0, sif.misaligned}, 32'h1);
    tick();
    chk("sh1_fault_valid", {31'b0, sif.fault_valid}, 32'h1);
    chk("sh1_fault_addr", sif.fault_addr, 32'h1);
    chk("sh1_fault_pc", sif.fault_pc, 32'h0000_0100);

    // SH aligned at daddr=2.
    drive(mk(OP_S, 3'b001), 32'h0000_0104, 32'h2, 32'h0000_1234);
    chk("sh2_we", {28'b0, sif.we_S}, 32'hC);
    chk("sh2_wdata", sif.wdata_S, 32'h1234_1234);
    chk("sh2_mis", {31'b0, sif.misaligned}, 32'h0);

    // SW misaligned at daddr=1 then 3: record stays on the first fault.
    drive(mk(OP_S, 3'b010), 32'h0000_0200, 32'h1, 32'hDEAD_BEEF);
    chk("sw1_we", {28'b0, sif.we_S}, 32'h0);
    chk("sw1_mis", {31'b0, sif.misaligned}, 32'h1);
    tick();
    drive(mk(OP_S, 3'b010), 32'h0000_0204, 32'h3, 32'hDEAD_BEEF);
    tick();
    chk("sticky_addr", sif.fault_addr, 32'h1);
    chk("sticky_pc", sif.fault_pc, 32'h0000_0100);

    // SW aligned.
    drive(mk(OP_S, 3'b010), 32'h0000_0208, 32'h0, 32'hDEAD_BEEF);
    chk("sw0_we", {28'b0, sif.we_S}, 32'hF);
    chk("sw0_wdata", sif.wdata_S, 32'hDEAD_BEEF);
    chk("sw0_mis", {31'b0, sif.misaligned}, 32'h0);

    // Immediate, independent of opcode.
    drive(32'hFE00_0FA3, 32'h0, 32'h0, 32'h0);
    chk("imm_neg1", sif.imm_S, 32'hFFFF_FFFF);
    drive({7'b0000001, 13'b0, 5'b00010, OP_R}, 32'h0, 32'h0, 32'h0);
    chk("imm_22", sif.imm_S, 32'h0000_0022);
    drive({7'b1000000, 13'b0, 5'b00001, OP_S}, 32'h0, 32'h0, 32'h0);
    chk("imm_m2047", sif.imm_S, 32'hFFFF_F801);

    // Reset clears the record; a coincident misaligned store is dropped.
    reset = 1'b0;
    drive(mk(OP_S, 3'b010), 32'h0000_0300, 32'h2, 32'h0);
    chk("rst_mis_comb", {31'b0, sif.misaligned}, 32'h1);
    tick();
    chk("rst2_fault_valid", {31'b0, sif.fault_valid}, 32'h0);
    chk("rst2_fault_pc", sif.fault_pc, 32'h0);
    chk("rst2_fault_addr", sif.fault_addr, 32'h0);
    reset = 1'b1;

    // Non-store opcode and illegal funct3 at misaligned addresses.
    drive(mk(OP_R, 3'b001), 32'h0000_0400, 32'h1, 32'hFFFF_FFFF);
    chk("rtype_is_store", {31'b0, sif.is_store}, 32'h0);
    chk("rtype_we", {28'b0, sif.we_S}, 32'h0);
    chk("rtype_mis", {31'b0, sif.misaligned}, 32'h0);
    chk("rtype_wdata", sif.wdata_S, 32'h0);
    tick();
    drive(mk(OP_S, 3'b011), 32'h0000_0404, 32'h1, 32'hFFFF_FFFF);
    chk("f3_011_is_store", {31'b0, sif.is_store}, 32'h0);
    chk("f3_011_we", {28'b0, sif.we_S}, 32'h0);
    chk("f3_011_mis", {31'b0, sif.misaligned}, 32'h0);
    tick();
    chk("illegal_no_fault", {31'b0, sif.fault_valid}, 32'h0);

    // idata[30]/[25] ignored; fresh fault after reset captured.
    drive(mk(OP_S, 3'b010) | 32'h4200_0000, 32'h0000_0500, 32'h3, 32'h0);
    chk("sw3_hi_is_store", {31'b0, sif.is_store}, 32'h1);
    chk("sw3_mis", {31'b0, sif.misaligned}, 32'h1);
    tick();
    chk("new_fault_valid", {31'b0, sif.fault_valid}, 32'h1);
    chk("new_fault_addr", sif.fault_addr, 32'h3);
    chk("new_fault_pc", sif.fault_pc, 32'h0000_0500);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
